// File: rtl/stable_matching_verify_seq.sv
// Sequential checker: is a given matching a stable marriage for the supplied preferences?
// Macro STABLE_MATCHING_VERIFY_COUNT_EN: full scan with saturating blocking-pair count.
module stable_matching_verify_seq #(
  parameter int S = 4,
  localparam int LOGS = (S > 1) ? $clog2(S) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [S*S*LOGS-1:0]    pref_a,
  input  logic [S*S*LOGS-1:0]    pref_b,
  input  logic [S*LOGS-1:0]      match,
  output logic                   busy,
  output logic                   done,
  output logic                   stable,
  output logic                   invalid,
  output logic [LOGS-1:0]        block_s,
  output logic [LOGS-1:0]        block_r,
  output logic [2*LOGS:0]        count
);

  localparam int CW = 2*LOGS + 1;

  typedef enum logic [1:0] {
    IDLE, INV, SCAN, DONE
  } state_t;

  state_t state, state_nx;

  logic [S*S*LOGS-1:0] pa, pb;
  logic [S*LOGS-1:0]   mt;
  logic [LOGS-1:0]     inv [S];
  logic [S-1:0]        seen;
  logic [LOGS-1:0]     idx, s, k;
  logic                bad, found, stable_q;
  logic [LOGS-1:0]     bs, br;

  logic [LOGS-1:0] m_r, cand, rival, rk_s, rk_m;
  logic            dup, partner, blocking;
  logic            last_r, last_s, last_k;

  assign m_r    = mt[int'(idx)*LOGS +: LOGS];
  assign dup    = seen[m_r];
  assign cand   = pa[(int'(s)*S + int'(k))*LOGS +: LOGS];
  assign rival  = mt[int'(cand)*LOGS +: LOGS];
  assign last_r = (idx == LOGS'(S-1));
  assign last_s = (s == LOGS'(S-1));
  assign last_k = (k == LOGS'(S-1));

  // ranks of s and of cand's current partner inside cand's list
  always_comb begin
    rk_s = '0;
    rk_m = '0;
    for (int j = 0; j < S; j++) begin
      if (pb[(int'(cand)*S + j)*LOGS +: LOGS] == s)
        rk_s = LOGS'(j);
      if (pb[(int'(cand)*S + j)*LOGS +: LOGS] == rival)
        rk_m = LOGS'(j);
    end
  end

  assign partner  = (cand == inv[s]);
  assign blocking = !partner && (rk_s < rk_m);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = INV;
      INV:  if (last_r) state_nx = (bad || dup) ? DONE : SCAN;
      SCAN: begin
`ifdef STABLE_MATCHING_VERIFY_COUNT_EN
        if ((partner || last_k) && last_s)
          state_nx = DONE;
`else
        if (blocking || ((partner || last_k) && last_s))
          state_nx = DONE;
`endif
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == INV) || (state == SCAN);
    done = (state == DONE);
  end

`ifdef STABLE_MATCHING_VERIFY_COUNT_EN
  logic [CW-1:0] cnt;
  assign count = cnt;
`else
  assign count = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa       <= '0;
      pb       <= '0;
      mt       <= '0;
      seen     <= '0;
      idx      <= '0;
      s        <= '0;
      k        <= '0;
      bad      <= 1'b0;
      found    <= 1'b0;
      stable_q <= 1'b0;
      bs       <= '0;
      br       <= '0;
      for (int i = 0; i < S; i++) inv[i] <= '0;
`ifdef STABLE_MATCHING_VERIFY_COUNT_EN
      cnt      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (start) begin
          pa       <= pref_a;
          pb       <= pref_b;
          mt       <= match;
          seen     <= '0;
          idx      <= '0;
          s        <= '0;
          k        <= '0;
          bad      <= 1'b0;
          found    <= 1'b0;
          stable_q <= 1'b0;
          bs       <= '0;
          br       <= '0;
          for (int i = 0; i < S; i++) inv[i] <= '0;
`ifdef STABLE_MATCHING_VERIFY_COUNT_EN
          cnt      <= '0;
`endif
        end
        INV: begin
          inv[m_r]  <= idx;
          seen[m_r] <= 1'b1;
          if (dup) bad <= 1'b1;
          idx <= idx + LOGS'(1);
        end
        SCAN: begin
          if (partner || last_k) begin
            s <= s + LOGS'(1);
            k <= '0;
          end else begin
            k <= k + LOGS'(1);
          end
          if (blocking) begin
            if (!found) begin
              found <= 1'b1;
              bs    <= s;
              br    <= cand;
            end
`ifdef STABLE_MATCHING_VERIFY_COUNT_EN
            if (cnt != '1) cnt <= cnt + CW'(1);
`endif
          end
        end
        DONE: stable_q <= !bad && !found;
        default: ;
      endcase
    end
  end

  assign stable  = stable_q;
  assign invalid = bad;
  assign block_s = bs;
  assign block_r = br;

endmodule
